// File: rtl/key_sched_pkg.sv
// Shared constants, shift table and types for the C/D key-half round sequencer.
package key_sched_pkg;

    localparam int HALF_W      = 56;
    localparam int ROUNDS      = 16;
    localparam int TOTAL_SHIFT = 28;
    localparam int AMT_W       = 5;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // SHIFT[1..16] stored zero-based
    localparam logic [1:0] SHIFT [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                          2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One-based lookup; out-of-range positions contribute no shift.
    function automatic logic [AMT_W-1:0] shift_of(input logic [4:0] n);
        logic [3:0] idx;
        idx = 4'(n - 5'd1);
        if (n >= 5'd1 && n <= 5'd16)
            return {3'b000, SHIFT[idx]};
        else
            return '0;
    endfunction

endpackage

// File: rtl/key_half_rotate.sv
// Combinational rotate of one key half by 0..TOTAL_SHIFT positions, left or right.
module key_half_rotate
    import key_sched_pkg::*;
#(
    parameter int W = HALF_W
) (
    input  logic [W-1:0]     din,
    input  logic [AMT_W-1:0] amt,
    input  logic             right,
    output logic [W-1:0]     dout
);

    localparam logic [6:0] WL = 7'(W);

    logic [6:0] back;

    // A zero amount shifts the wrapped term by W, which yields zero and leaves din intact.
    assign back = WL - {2'b00, amt};

    always_comb begin
        if (right)
            dout = (din >> amt) | (din << back);
        else
            dout = (din << amt) | (din >> back);
    end

endmodule

// File: rtl/key_round_sequencer.sv
// Emits the 16 rotated C/D key halves one round at a time over valid/ready.
// Build option KEY_ZEROIZE_EN clears the halves and round index when Done pulses.
module key_round_sequencer
    import key_sched_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Mode,
    input  logic [HALF_W-1:0] C0,
    input  logic [HALF_W-1:0] D0,
    output logic [HALF_W-1:0] Cn_out,
    output logic [HALF_W-1:0] Dn_out,
    output logic [3:0]        Round_out,
    output logic              Valid,
    input  logic              Ready,
    output logic              Busy,
    output logic              Done
);

    // state | meaning
    // IDLE  | waiting for Start (ignored during the Done cycle)
    // RUN   | presenting round Round_out, advancing on Valid && Ready

    state_t            state, state_nx;
    logic [HALF_W-1:0] c_reg, c_nx, d_reg, d_nx;
    logic [3:0]        round_reg, round_nx;
    logic              mode_reg, mode_nx;
    logic              valid_reg, valid_nx;
    logic              done_reg, done_nx;

    logic [HALF_W-1:0] rot_c_in, rot_d_in, rot_c, rot_d;
    logic [AMT_W-1:0]  rot_amt;
    logic              rot_right;

    key_half_rotate #(.W(HALF_W)) u_rot_c (
        .din   (rot_c_in),
        .amt   (rot_amt),
        .right (rot_right),
        .dout  (rot_c)
    );

    key_half_rotate #(.W(HALF_W)) u_rot_d (
        .din   (rot_d_in),
        .amt   (rot_amt),
        .right (rot_right),
        .dout  (rot_d)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            c_reg     <= '0;
            d_reg     <= '0;
            round_reg <= '0;
            mode_reg  <= MODE_ENC;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state     <= state_nx;
            c_reg     <= c_nx;
            d_reg     <= d_nx;
            round_reg <= round_nx;
            mode_reg  <= mode_nx;
            valid_reg <= valid_nx;
            done_reg  <= done_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        c_nx      = c_reg;
        d_nx      = d_reg;
        round_nx  = round_reg;
        mode_nx   = mode_reg;
        valid_nx  = valid_reg;
        done_nx   = 1'b0;
        rot_c_in  = c_reg;
        rot_d_in  = d_reg;
        rot_amt   = '0;
        rot_right = 1'b0;

        case (state)
            IDLE: begin
                // Decrypt starts at the fully rotated key, i.e. the last encrypt round.
                rot_c_in = C0;
                rot_d_in = D0;
                rot_amt  = (Mode == MODE_DEC) ? AMT_W'(TOTAL_SHIFT) : AMT_W'(1);
                if (Start && !done_reg) begin
                    mode_nx  = Mode;
                    c_nx     = rot_c;
                    d_nx     = rot_d;
                    round_nx = '0;
                    valid_nx = 1'b1;
                    state_nx = RUN;
                end
            end

            RUN: begin
                rot_right = mode_reg;
                rot_amt   = (mode_reg == MODE_DEC) ? shift_of(5'd16 - {1'b0, round_reg})
                                                   : shift_of({1'b0, round_reg} + 5'd2);
                if (Ready) begin
                    if (round_reg == 4'(ROUNDS - 1)) begin
                        valid_nx = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = IDLE;
`ifdef KEY_ZEROIZE_EN
                        c_nx     = '0;
                        d_nx     = '0;
                        round_nx = '0;
`endif
                    end else begin
                        c_nx     = rot_c;
                        d_nx     = rot_d;
                        round_nx = round_reg + 4'd1;
                    end
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    assign Cn_out    = c_reg;
    assign Dn_out    = d_reg;
    assign Round_out = round_reg;
    assign Valid     = valid_reg;
    assign Busy      = (state != IDLE);
    assign Done      = done_reg;

endmodule

// File: tb/tb_key_round_sequencer.sv
// Randomized self-checking bench for key_round_sequencer against a schedule-level model.
module tb_key_round_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start, Mode, Ready;
    logic [55:0] C0, D0;
    logic [55:0] Cn_out, Dn_out;
    logic [3:0]  Round_out;
    logic        Valid, Busy, Done;

    int n_checks = 0;
    int n_pass   = 0;

    key_round_sequencer dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Mode      (Mode),
        .C0        (C0),
        .D0        (D0),
        .Cn_out    (Cn_out),
        .Dn_out    (Dn_out),
        .Round_out (Round_out),
        .Valid     (Valid),
        .Ready     (Ready),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Key half for round r: left rotation by the cumulative DES shift count.
    function automatic logic [55:0] exp_half(input logic [55:0] x, input logic dec, input int r);
        int sh [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
        int n, amt;
        logic [55:0] y;
        n   = dec ? (16 - r) : (r + 1);
        amt = 0;
        for (int i = 0; i < n; i++) amt += sh[i];
        y = '0;
        for (int i = 0; i < 56; i++) y[(i + amt) % 56] = x[i];
        return y;
    endfunction

    logic        m_busy = 0, m_valid = 0, m_done = 0, m_have = 0, m_mode = 0;
    int          m_round = 0;
    logic [55:0] m_c0 = '0, m_d0 = '0;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_busy = 0; m_valid = 0; m_done = 0; m_have = 0; m_mode = 0;
            m_round = 0; m_c0 = '0; m_d0 = '0;
        end else begin
            logic nd;
            nd = 0;
            if (!m_busy) begin
                if (Start && !m_done) begin
                    m_busy = 1; m_valid = 1; m_have = 1; m_round = 0;
                    m_mode = Mode; m_c0 = C0; m_d0 = D0;
                end
            end else if (Ready) begin
                if (m_round == 15) begin
                    m_busy = 0; m_valid = 0; nd = 1;
`ifdef KEY_ZEROIZE_EN
                    m_have = 0; m_round = 0;
`endif
                end else begin
                    m_round++;
                end
            end
            m_done = nd;
        end
    end

    always @(negedge Clk) begin
        logic [55:0] ec, ed;
        ec = m_have ? exp_half(m_c0, m_mode, m_round) : '0;
        ed = m_have ? exp_half(m_d0, m_mode, m_round) : '0;
        check("valid", Valid, m_valid);
        check("busy", Busy, m_busy);
        check("done", Done, m_done);
        check("round", Round_out, m_have ? 64'(m_round) : 64'd0);
        check("cn", Cn_out, ec);
        check("dn", Dn_out, ed);
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic start_sched(input logic dec, input logic [55:0] c, input logic [55:0] d);
        Start = 1'b1; Mode = dec; C0 = c; D0 = d;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((Busy || Done) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) timeout_fail("wait_idle");
    endtask

    function automatic logic [55:0] rnd56();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[55:0];
    endfunction

    initial begin
        logic [55:0] lit [4];
        int n;
        lit = '{56'h02, 56'h04, 56'h10, 56'h40};
        Reset_n = 1'b0; Start = 0; Mode = 0; C0 = '0; D0 = '0; Ready = 1'b1;
        repeat (3) @(posedge Clk);
        #2 Reset_n = 1'b1;
        tick();

        // Encrypt trace of a single set bit
        start_sched(1'b0, 56'h1, 56'h0);
        for (int k = 0; k < 4; k++) begin
            check("enc_lit_cn", Cn_out, lit[k]);
            tick();
        end
        repeat (11) tick();
        check("enc_r15_round", Round_out, 15);
        check("enc_r15_cn", Cn_out, 56'h00000010000000);
        tick();
        check("enc_done_at_16", Done, 1);
        tick();
        check("enc_done_once", Done, 0);

        // Decrypt trace, then a Start during the Done cycle must be ignored
        start_sched(1'b1, 56'h1, 56'h0);
        check("dec_r0_cn", Cn_out, 56'h00000010000000);
        tick();
        check("dec_r1_cn", Cn_out, 56'h00000008000000);
        n = 0;
        while (!Done && n < 40) begin tick(); n++; end
        if (n >= 40) timeout_fail("dec_wait_done");
        Start = 1'b1; Mode = 1'b0; C0 = rnd56(); D0 = rnd56();
        tick();
        Start = 1'b0;
        check("start_on_done_ignored", Busy, 0);
        wait_idle();

        // Backpressure at round 5
        start_sched(1'b0, rnd56(), rnd56());
        repeat (5) tick();
        Ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_round", Round_out, 5);
            check("bp_valid", Valid, 1);
        end
        Ready = 1'b1;
        wait_idle();

        // Start while busy at round 7
        start_sched(1'b1, rnd56(), rnd56());
        repeat (7) tick();
        Start = 1'b1; Mode = 1'b0; C0 = rnd56(); D0 = rnd56();
        tick();
        Start = 1'b0;
        check("busy_start_ignored", Busy, 1);
        wait_idle();

        // Asynchronous reset at round 9
        start_sched(1'b0, rnd56(), rnd56());
        repeat (9) tick();
        Reset_n = 1'b0;
        #1;
        check("rst_cn", Cn_out, 0);
        check("rst_dn", Dn_out, 0);
        check("rst_round", Round_out, 0);
        check("rst_valid", Valid, 0);
        check("rst_busy", Busy, 0);
        repeat (2) tick();
        Reset_n = 1'b1;
        tick();
        start_sched(1'b0, rnd56(), rnd56());
        check("post_rst_round", Round_out, 0);
        wait_idle();

        // All-ones key: cleared or held after Done depending on build
        start_sched(1'b0, 56'hFFFFFFFFFFFFFF, 56'hFFFFFFFFFFFFFF);
        wait_idle();
`ifdef KEY_ZEROIZE_EN
        check("zeroize_cn", Cn_out, 0);
        check("zeroize_dn", Dn_out, 0);
`else
        check("hold_cn", Cn_out, 56'hFFFFFFFFFFFFFF);
        check("hold_dn", Dn_out, 56'hFFFFFFFFFFFFFF);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            Start = ($urandom_range(0, 7) == 0);
            Mode  = 1'($urandom_range(0, 1));
            C0    = rnd56();
            D0    = rnd56();
            Ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        Start = 1'b0;
        Ready = 1'b1;
        wait_idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
